minmax_seq: RTL and testbench



---
 rtl/minmax_pkg.sv | 13 +
 rtl/minmax_seq_geq6.sv | 10 +
 rtl/minmax_seq.sv | 166 ++++++++++++++++
 tb/tb_minmax_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// Shared defaults and state encoding for the minmax_seq frame min/max tracker.
package minmax_pkg;

   localparam int DATA_W_DEF = 6;
   localparam int CNT_W_DEF  = 8;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WAIT    = 3'd1;
   localparam logic [2:0] ST_CMP_MAX = 3'd2;
   localparam logic [2:0] ST_CMP_MIN = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/minmax_seq_geq6.sv
// Fixed-width 6-bit signed a >= b comparator, shared by the max and min decisions.
module geq6 (
   input  logic signed [5:0] a_i,
   input  logic signed [5:0] b_i,
   output logic              ge_o
);

   assign ge_o = (a_i >= b_i);

endmodule

// File: rtl/minmax_seq.sv
// Sequential signed min/max/count tracker over sample frames, one shared comparator.
// Define MINMAX_IDX_EN to add res_max_idx/res_min_idx position outputs.
module minmax_seq
   import minmax_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_last,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic signed [DATA_W-1:0] res_max,
   output logic signed [DATA_W-1:0] res_min,
   output logic [CNT_W-1:0]         res_count,
   output logic                     res_sat
`ifdef MINMAX_IDX_EN
   ,
   output logic [CNT_W-1:0]         res_max_idx,
   output logic [CNT_W-1:0]         res_min_idx
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [2:0]               state_q, state_d;
   logic signed [DATA_W-1:0] max_q, max_d, min_q, min_d, smp_q, smp_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic                     sat_q, sat_d, last_q, last_d;
   logic signed [DATA_W-1:0] cmp_a, cmp_b;
   logic                     ge;
   logic                     accept;
`ifdef MINMAX_IDX_EN
   logic [CNT_W-1:0]         max_idx_q, max_idx_d, min_idx_q, min_idx_d, smp_idx_q, smp_idx_d;
   logic                     frz_q, frz_d;
`endif

   assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_WAIT);
   assign res_valid = (state_q == ST_DONE);
   assign accept    = in_valid && in_ready;

   // Operand order flips between phases so a single ">=" serves both updates.
   always_comb begin
      cmp_a = smp_q;
      cmp_b = max_q;
      if (state_q == ST_CMP_MIN) begin
         cmp_a = min_q;
         cmp_b = smp_q;
      end
   end

   geq6 u_geq6 (
      .a_i  (cmp_a),
      .b_i  (cmp_b),
      .ge_o (ge)
   );

   always_comb begin
      state_d = state_q;
      max_d   = max_q;
      min_d   = min_q;
      smp_d   = smp_q;
      count_d = count_q;
      sat_d   = sat_q;
      last_d  = last_q;
`ifdef MINMAX_IDX_EN
      max_idx_d = max_idx_q;
      min_idx_d = min_idx_q;
      smp_idx_d = smp_idx_q;
      frz_d     = frz_q;
`endif
      case (state_q)
         ST_IDLE: if (accept) begin
            max_d   = in_data;
            min_d   = in_data;
            count_d = CNT_W'(1);
            sat_d   = 1'b0;
            last_d  = in_last;
            state_d = in_last ? ST_DONE : ST_WAIT;
`ifdef MINMAX_IDX_EN
            max_idx_d = '0;
            min_idx_d = '0;
            frz_d     = 1'b0;
`endif
         end
         ST_WAIT: if (accept) begin
            smp_d  = in_data;
            last_d = in_last;
            if (count_q == CNT_MAX) sat_d = 1'b1;
            else count_d = count_q + CNT_W'(1);
`ifdef MINMAX_IDX_EN
            // Position no longer representable once the counter is pinned.
            smp_idx_d = count_q;
            frz_d     = frz_q || (count_q == CNT_MAX);
`endif
            state_d = ST_CMP_MAX;
         end
         ST_CMP_MAX: begin
            if (ge) begin
               max_d = smp_q;
`ifdef MINMAX_IDX_EN
               if (!frz_q) max_idx_d = smp_idx_q;
`endif
            end
            state_d = ST_CMP_MIN;
         end
         ST_CMP_MIN: begin
            if (ge) begin
               min_d = smp_q;
`ifdef MINMAX_IDX_EN
               if (!frz_q) min_idx_d = smp_idx_q;
`endif
            end
            state_d = last_q ? ST_DONE : ST_WAIT;
         end
         ST_DONE: if (res_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         max_q   <= '0;
         min_q   <= '0;
         smp_q   <= '0;
         count_q <= '0;
         sat_q   <= 1'b0;
         last_q  <= 1'b0;
`ifdef MINMAX_IDX_EN
         max_idx_q <= '0;
         min_idx_q <= '0;
         smp_idx_q <= '0;
         frz_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         max_q   <= max_d;
         min_q   <= min_d;
         smp_q   <= smp_d;
         count_q <= count_d;
         sat_q   <= sat_d;
         last_q  <= last_d;
`ifdef MINMAX_IDX_EN
         max_idx_q <= max_idx_d;
         min_idx_q <= min_idx_d;
         smp_idx_q <= smp_idx_d;
         frz_q     <= frz_d;
`endif
      end
   end

   assign res_max   = max_q;
   assign res_min   = min_q;
   assign res_count = count_q;
   assign res_sat   = sat_q;
`ifdef MINMAX_IDX_EN
   assign res_max_idx = max_idx_q;
   assign res_min_idx = min_idx_q;
`endif

endmodule

// File: tb/tb_minmax_seq.sv
// Directed self-checking bench for minmax_seq (index checks only when MINMAX_IDX_EN is defined).
module tb_minmax_seq;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_last = 1'b0;
   logic              res_ready = 1'b0;
   logic signed [5:0] in_data = '0;
   logic              in_ready, res_valid, res_sat;
   logic signed [5:0] res_max, res_min;
   logic [7:0]        res_count;
`ifdef MINMAX_IDX_EN
   logic [7:0]        res_max_idx, res_min_idx;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   minmax_seq #(.DATA_W(6), .CNT_W(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_max   (res_max),
      .res_min   (res_min),
      .res_count (res_count),
      .res_sat   (res_sat)
`ifdef MINMAX_IDX_EN
      ,
      .res_max_idx (res_max_idx),
      .res_min_idx (res_min_idx)
`endif
   );

   // Offers one sample, waiting (bounded) for in_ready; returns 1 ns after the accepting edge.
   task automatic push(input logic signed [5:0] d, input logic l);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL push_ready_timeout: in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic release_result();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, res_valid, res_max, res_min, res_count, res_sat} !== {1'b1, 1'b0, 6'h00, 6'h00, 8'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: rdy=%b vld=%b max=%h min=%h cnt=%0d sat=%b required 1 0 00 00 0 0",
                  in_ready, res_valid, res_max, res_min, res_count, res_sat);
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_frame();
      push(6'sd5, 1'b0);
      push(-6'sd3, 1'b0);
      push(6'sd31, 1'b0);
      push(-6'sd32, 1'b0);
      push(6'sd0, 1'b1);
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL frame_latency_c1: res_valid=%b required 0", res_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL frame_latency_c2: res_valid=%b required 0", res_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1) begin
         errors++;
         $display("FAIL frame_latency_c3: res_valid=%b required 1", res_valid);
      end
      checks++;
      if ({res_max, res_min, res_count, res_sat} !== {6'h1F, 6'h20, 8'd5, 1'b0}) begin
         errors++;
         $display("FAIL frame_result: max=%h min=%h cnt=%0d sat=%b required 1f 20 5 0",
                  res_max, res_min, res_count, res_sat);
      end
`ifdef MINMAX_IDX_EN
      checks++;
      if ({res_max_idx, res_min_idx} !== {8'd2, 8'd3}) begin
         errors++;
         $display("FAIL frame_idx: max_idx=%0d min_idx=%0d required 2 3", res_max_idx, res_min_idx);
      end
`endif
      release_result();
      checks++;
      if ({in_ready, res_valid} !== 2'b10) begin
         errors++;
         $display("FAIL frame_to_idle: rdy=%b vld=%b required 1 0", in_ready, res_valid);
      end
   endtask

   task automatic test_single();
      push(-6'sd1, 1'b1);
      checks++;
      if ({res_valid, in_ready, res_max, res_min, res_count, res_sat} !== {1'b1, 1'b0, 6'h3F, 6'h3F, 8'd1, 1'b0}) begin
         errors++;
         $display("FAIL single_result: vld=%b rdy=%b max=%h min=%h cnt=%0d sat=%b required 1 0 3f 3f 1 0",
                  res_valid, in_ready, res_max, res_min, res_count, res_sat);
      end
      release_result();
   endtask

   task automatic test_ties();
      push(6'sd7, 1'b0);
      push(6'sd7, 1'b0);
      push(6'sd7, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({res_valid, res_max, res_min, res_count} !== {1'b1, 6'h07, 6'h07, 8'd3}) begin
         errors++;
         $display("FAIL ties_result: vld=%b max=%h min=%h cnt=%0d required 1 07 07 3",
                  res_valid, res_max, res_min, res_count);
      end
`ifdef MINMAX_IDX_EN
      checks++;
      if ({res_max_idx, res_min_idx} !== {8'd2, 8'd2}) begin
         errors++;
         $display("FAIL ties_idx: max_idx=%0d min_idx=%0d required 2 2", res_max_idx, res_min_idx);
      end
`endif
      release_result();
   endtask

   task automatic test_backpressure();
      push(6'sd3, 1'b0);
      push(-6'sd4, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 6'sd25;
         in_last  = 1'b1;
         @(posedge clk); #1;
         checks++;
         if ({res_valid, in_ready, res_max, res_min, res_count} !== {1'b1, 1'b0, 6'h03, 6'h3C, 8'd2}) begin
            errors++;
            $display("FAIL backpressure_hold[%0d]: vld=%b rdy=%b max=%h min=%h cnt=%0d required 1 0 03 3c 2",
                     i, res_valid, in_ready, res_max, res_min, res_count);
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      release_result();
      checks++;
      if ({in_ready, res_valid, res_max, res_min, res_count} !== {1'b1, 1'b0, 6'h03, 6'h3C, 8'd2}) begin
         errors++;
         $display("FAIL backpressure_idle: rdy=%b vld=%b max=%h min=%h cnt=%0d required 1 0 03 3c 2",
                  in_ready, res_valid, res_max, res_min, res_count);
      end
   endtask

   task automatic test_saturation();
      logic [31:0] v;
      for (int i = 0; i < 260; i++) begin
         v = i;
         push(v[5:0], (i == 259));
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({res_valid, res_max, res_min, res_count, res_sat} !== {1'b1, 6'h1F, 6'h20, 8'd255, 1'b1}) begin
         errors++;
         $display("FAIL sat_result: vld=%b max=%h min=%h cnt=%0d sat=%b required 1 1f 20 255 1",
                  res_valid, res_max, res_min, res_count, res_sat);
      end
`ifdef MINMAX_IDX_EN
      checks++;
      if ({res_max_idx, res_min_idx} !== {8'd223, 8'd224}) begin
         errors++;
         $display("FAIL sat_idx: max_idx=%0d min_idx=%0d required 223 224", res_max_idx, res_min_idx);
      end
`endif
      release_result();
      push(6'sd1, 1'b1);
      checks++;
      if ({res_valid, res_count, res_sat} !== {1'b1, 8'd1, 1'b0}) begin
         errors++;
         $display("FAIL sat_cleared: vld=%b cnt=%0d sat=%b required 1 1 0", res_valid, res_count, res_sat);
      end
      release_result();
   endtask

   task automatic test_reset_midframe();
      push(6'sd10, 1'b0);
      push(6'sd20, 1'b0);
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, res_valid, res_max, res_min, res_count, res_sat} !== {1'b1, 1'b0, 6'h00, 6'h00, 8'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_async: rdy=%b vld=%b max=%h min=%h cnt=%0d sat=%b required 1 0 00 00 0 0",
                  in_ready, res_valid, res_max, res_min, res_count, res_sat);
      end
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      push(-6'sd32, 1'b0);
      push(6'sd31, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({res_valid, res_max, res_min, res_count, res_sat} !== {1'b1, 6'h1F, 6'h20, 8'd2, 1'b0}) begin
         errors++;
         $display("FAIL reset_fresh_frame: vld=%b max=%h min=%h cnt=%0d sat=%b required 1 1f 20 2 0",
                  res_valid, res_max, res_min, res_count, res_sat);
      end
      release_result();
   endtask

   initial begin
      test_reset();
      test_frame();
      test_single();
      test_ties();
      test_backpressure();
      test_saturation();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
